boreal_vns_sequencer: RTL and testbench

- Sequences vagus-nerve-stimulation (VNS) bursts for the Boreal Neuro-Core: amplitude ramp, on/off duty cycle, and burst count per session.
- Consumes ad_guard_active from the autonomic-dysreflexia guard and enforces the "Vagus Brake": immediate stimulus cut, hold while the guard is asserted, then a mandatory cooldown.
- Sits between the host/session controller (start request/ack handshake) and the analog stimulator front-end (stim_active, stim_amp).

---
 rtl/boreal_vns_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_boreal_vns_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boreal_vns_sequencer.sv
// VNS burst sequencer: amplitude ramp, on/off duty cycle, burst counting and the Vagus Brake interlock.
// Optional macro BOREAL_VNS_BRAKE_CNT_EN adds a saturating brake_events counter output.
module boreal_vns_sequencer #(
  parameter int AMP_W       = 8,
  parameter int MAX_AMP     = 200,
  parameter int RAMP_STEP   = 4,
  parameter int ON_CYCLES   = 1000,
  parameter int OFF_CYCLES  = 4000,
  parameter int N_BURSTS    = 8,
  parameter int COOL_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start_req,
  output logic             start_ack,
  input  logic [AMP_W-1:0] cfg_amp,
  input  logic             ad_guard_active,
  output logic             stim_active,
  output logic [AMP_W-1:0] stim_amp,
  output logic [7:0]       burst_count,
  output logic             brake_flag,
  output logic             session_done,
`ifdef BOREAL_VNS_BRAKE_CNT_EN
  output logic [2:0]       state,
  output logic [7:0]       brake_events
`else
  output logic [2:0]       state
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP     = 3'd1,
    S_ON       = 3'd2,
    S_OFF      = 3'd3,
    S_BRAKE    = 3'd4,
    S_COOLDOWN = 3'd5
  } state_t;

  localparam int               AW1      = AMP_W + 1;
  localparam logic [15:0]      ON_LAST  = 16'(ON_CYCLES - 1);
  localparam logic [15:0]      OFF_LAST = 16'(OFF_CYCLES - 1);
  localparam logic [15:0]      COOL_LAST = 16'(COOL_CYCLES - 1);
  localparam logic [7:0]       N_LAST   = 8'(N_BURSTS);
  localparam logic [AMP_W-1:0] MAX_T    = AMP_W'(MAX_AMP);
  localparam logic [AMP_W:0]   STEP_X   = AW1'(RAMP_STEP);

  state_t           st;
  logic [15:0]      timer;
  logic [AMP_W-1:0] target;
  logic [AMP_W:0]   ramp_sum;
  logic             accept;
  logic             brake_hit;
  logic             in_burst;

  function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W-1:0] req);
    return (req > MAX_T) ? MAX_T : req;
  endfunction

  // One extra bit keeps the ramp increment from wrapping near full scale.
  assign ramp_sum  = {1'b0, stim_amp} + STEP_X;
  assign accept    = enable && start_req && !ad_guard_active && (cfg_amp != {AMP_W{1'b0}});
  assign brake_hit = (st != S_IDLE) && ad_guard_active;
  assign in_burst  = (st == S_RAMP) || (st == S_ON) || (st == S_OFF);
  assign state     = st;

  // Main sequencer: brake beats abort, abort beats the normal phase progression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_IDLE;
      timer        <= 16'd0;
      target       <= {AMP_W{1'b0}};
      start_ack    <= 1'b0;
      stim_active  <= 1'b0;
      stim_amp     <= {AMP_W{1'b0}};
      burst_count  <= 8'd0;
      brake_flag   <= 1'b0;
      session_done <= 1'b0;
    end else begin
      start_ack    <= 1'b0;
      session_done <= 1'b0;
      if (brake_hit) begin
        st          <= S_BRAKE;
        stim_amp    <= {AMP_W{1'b0}};
        stim_active <= 1'b0;
        brake_flag  <= 1'b1;
        timer       <= 16'd0;
      end else if (!enable && in_burst) begin
        st          <= S_IDLE;
        stim_amp    <= {AMP_W{1'b0}};
        stim_active <= 1'b0;
        timer       <= 16'd0;
      end else begin
        case (st)
          S_IDLE: begin
            stim_amp <= {AMP_W{1'b0}};
            if (accept) begin
              start_ack   <= 1'b1;
              target      <= clamp_amp(cfg_amp);
              burst_count <= 8'd0;
              brake_flag  <= 1'b0;
              timer       <= 16'd0;
              stim_active <= 1'b1;
              st          <= S_RAMP;
            end else begin
              stim_active <= 1'b0;
            end
          end
          S_RAMP: begin
            if (ramp_sum >= {1'b0, target}) begin
              stim_amp <= target;
              timer    <= 16'd0;
              st       <= S_ON;
            end else begin
              stim_amp <= ramp_sum[AMP_W-1:0];
            end
          end
          S_ON: begin
            if (timer == ON_LAST) begin
              stim_amp    <= {AMP_W{1'b0}};
              stim_active <= 1'b0;
              burst_count <= burst_count + 8'd1;
              timer       <= 16'd0;
              st          <= S_OFF;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          S_OFF: begin
            stim_amp <= {AMP_W{1'b0}};
            if (timer == OFF_LAST) begin
              timer <= 16'd0;
              if (burst_count == N_LAST) begin
                session_done <= 1'b1;
                st           <= S_IDLE;
              end else begin
                stim_active <= 1'b1;
                st          <= S_RAMP;
              end
            end else begin
              timer <= timer + 16'd1;
            end
          end
          S_BRAKE: begin
            // A still-asserted guard is caught by brake_hit, so reaching here means release.
            timer <= 16'd0;
            st    <= S_COOLDOWN;
          end
          S_COOLDOWN: begin
            if (timer == COOL_LAST) begin
              timer <= 16'd0;
              st    <= S_IDLE;
            end else begin
              timer <= timer + 16'd1;
            end
          end
          default: begin
            st          <= S_IDLE;
            timer       <= 16'd0;
            stim_amp    <= {AMP_W{1'b0}};
            stim_active <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BOREAL_VNS_BRAKE_CNT_EN
  // Lifetime tally of brake entries; holding in BRAKE is not a new entry, and starts do not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brake_events <= 8'd0;
    end else if (brake_hit && (st != S_BRAKE) && (brake_events != 8'hFF)) begin
      brake_events <= brake_events + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_boreal_vns_sequencer.sv
// Scoreboard bench for boreal_vns_sequencer: a closed-form session model predicts every cycle's outputs.
module tb_boreal_vns_sequencer;

  localparam int AMP_W = 8;
  localparam int MAXA  = 200;
  localparam int STEP  = 4;
  localparam int ON_C  = 10;
  localparam int OFF_C = 20;
  localparam int NB    = 2;
  localparam int COOL  = 2000;

  logic       clk = 1'b0;
  logic       rst, enable, start_req, ad_guard_active;
  logic [7:0] cfg_amp;
  logic       start_ack, stim_active, brake_flag, session_done;
  logic [7:0] stim_amp, burst_count, dut_bev;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       act;
    logic [7:0] amp;
    logic [7:0] bc;
    logic       flag;
    logic       ack;
    logic       done;
    logic [7:0] bev;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   ack_cnt = 0;
  int   done_cnt = 0;
  int   max_amp = 0;

  boreal_vns_sequencer #(
    .AMP_W(AMP_W), .MAX_AMP(MAXA), .RAMP_STEP(STEP), .ON_CYCLES(ON_C),
    .OFF_CYCLES(OFF_C), .N_BURSTS(NB), .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .start_req(start_req), .start_ack(start_ack),
    .cfg_amp(cfg_amp), .ad_guard_active(ad_guard_active), .stim_active(stim_active),
    .stim_amp(stim_amp), .burst_count(burst_count), .brake_flag(brake_flag),
    .session_done(session_done),
`ifdef BOREAL_VNS_BRAKE_CNT_EN
    .state(state), .brake_events(dut_bev)
`else
    .state(state)
`endif
  );

`ifndef BOREAL_VNS_BRAKE_CNT_EN
  assign dut_bev = 8'd0;
`endif

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 session, 2 brake, 3 cooldown.
  int         m_mode, m_t, m_R, m_L, m_cool, m_bev;
  logic [7:0] m_tgt, m_bc;
  logic       m_flag, m_ack, m_done;
  rec_t       m_e;

  // Outputs during session cycle t follow directly from the burst geometry.
  function automatic rec_t sess_rec(input int t);
    rec_t e;
    int   b, r;
    e = '0;
    b = t / m_L;
    r = t % m_L;
    if (r < m_R) begin
      e.st = 3'd1; e.act = 1'b1; e.amp = 8'(r * STEP);
    end else if (r < m_R + ON_C) begin
      e.st = 3'd2; e.act = 1'b1; e.amp = m_tgt;
    end else begin
      e.st = 3'd3;
    end
    e.bc   = 8'(b + ((r >= m_R + ON_C) ? 1 : 0));
    e.flag = m_flag;
    return e;
  endfunction

  initial begin
    m_mode = 0; m_t = 0; m_R = 1; m_L = 1; m_cool = 0; m_bev = 0;
    m_tgt = 8'd0; m_bc = 8'd0; m_flag = 1'b0;
    forever begin
      @(posedge clk);
      m_ack = 1'b0;
      m_done = 1'b0;
      if (rst) begin
        m_mode = 0; m_bc = 8'd0; m_flag = 1'b0; m_bev = 0; m_t = 0; m_cool = 0;
      end else if (m_mode != 0 && ad_guard_active) begin
        if (m_mode == 1) begin
          m_e = sess_rec(m_t);
          m_bc = m_e.bc;
        end
        if (m_mode != 2 && m_bev < 255) m_bev++;
        m_mode = 2;
        m_flag = 1'b1;
      end else begin
        case (m_mode)
          0: if (enable && start_req && !ad_guard_active && cfg_amp != 8'd0) begin
               m_tgt = (cfg_amp > 8'(MAXA)) ? 8'(MAXA) : cfg_amp;
               m_R = (int'(m_tgt) + STEP - 1) / STEP;
               m_L = m_R + ON_C + OFF_C;
               m_t = 0; m_bc = 8'd0; m_flag = 1'b0; m_ack = 1'b1; m_mode = 1;
             end
          1: if (!enable) begin
               m_e = sess_rec(m_t);
               m_bc = m_e.bc;
               m_mode = 0;
             end else if (m_t == NB * m_L - 1) begin
               m_bc = 8'(NB); m_done = 1'b1; m_mode = 0;
             end else begin
               m_t++;
             end
          2: begin m_mode = 3; m_cool = 0; end
          3: if (m_cool == COOL - 1) m_mode = 0; else m_cool++;
          default: m_mode = 0;
        endcase
      end
      if (m_mode == 1) begin
        m_e = sess_rec(m_t);
      end else begin
        m_e = '0;
        m_e.st = (m_mode == 2) ? 3'd4 : (m_mode == 3) ? 3'd5 : 3'd0;
        m_e.bc = m_bc;
        m_e.flag = m_flag;
      end
      m_e.ack = m_ack;
      m_e.done = m_done;
`ifdef BOREAL_VNS_BRAKE_CNT_EN
      m_e.bev = 8'(m_bev);
`else
      m_e.bev = 8'd0;
`endif
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    rec_t e, a;
    forever begin
      @(negedge clk);
      if (start_ack) ack_cnt++;
      if (session_done) done_cnt++;
      if (int'(stim_amp) > max_amp) max_amp = int'(stim_amp);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, stim_active, stim_amp, burst_count, brake_flag, start_ack, session_done, dut_bev};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_rec t=%0t got st=%0d act=%0b amp=%0d bc=%0d flag=%0b ack=%0b done=%0b bev=%0d want st=%0d act=%0b amp=%0d bc=%0d flag=%0b ack=%0b done=%0b bev=%0d",
                   $time, a.st, a.act, a.amp, a.bc, a.flag, a.ack, a.done, a.bev,
                   e.st, e.act, e.amp, e.bc, e.flag, e.ack, e.done, e.bev);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_for(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state), int'(s));
  endtask

  task automatic request(input logic [7:0] amp, output int lat);
    int n = 0;
    cfg_amp = amp;
    enable = 1'b1;
    start_req = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!start_ack && n < 10);
    check("ack_seen", int'(start_ack), 1);
    start_req = 1'b0;
    lat = n;
  endtask

  initial begin
    int lat, d0, a0, n, guard_left;
    rst = 1'b1; enable = 1'b0; start_req = 1'b0; cfg_amp = 8'd0; ad_guard_active = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_amp", int'(stim_amp), 0);
    rst = 1'b0;
    @(negedge clk);

    // Normal two-burst session.
    d0 = done_cnt;
    request(8'd100, lat);
    check("ack_latency", lat, 1);
    wait_for(3'd0, 300, "normal_idle");
    #1;
    check("normal_done", done_cnt - d0, 1);
    check("normal_bc", int'(burst_count), 2);

    // Clamp of an over-range request.
    max_amp = 0;
    request(8'd250, lat);
    wait_for(3'd2, 100, "clamp_on");
    #1;
    check("clamp_on_amp", int'(stim_amp), 200);
    wait_for(3'd0, 400, "clamp_idle");
    #1;
    check("clamp_max", max_amp, 200);

    // Brake during ON for 5 cycles, full cooldown, session aborted.
    d0 = done_cnt;
    request(8'd100, lat);
    wait_for(3'd2, 100, "brake_reach_on");
    repeat (3) @(negedge clk);
    ad_guard_active = 1'b1;
    @(negedge clk);
    check("brake_amp_cut", int'(stim_amp), 0);
    repeat (4) @(negedge clk);
    ad_guard_active = 1'b0;
    wait_for(3'd5, 10, "brake_to_cool");
    wait_for(3'd0, 2100, "brake_idle");
    #1;
    check("brake_flag", int'(brake_flag), 1);
    check("brake_no_done", done_cnt - d0, 0);

    // Guard re-pulse at cooldown cycle 1500 restarts the full cooldown.
    request(8'd60, lat);
    ad_guard_active = 1'b1;
    @(negedge clk);
    ad_guard_active = 1'b0;
    wait_for(3'd5, 10, "repulse_cool1");
    repeat (1500) @(negedge clk);
    ad_guard_active = 1'b1;
    @(negedge clk);
    check("repulse_brake", int'(state), 4);
    ad_guard_active = 1'b0;
    wait_for(3'd5, 10, "repulse_cool2");
    n = 0;
    while (state == 3'd5 && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check("cool_len", n, 2000);

    // Start blocking: guard high, then zero amplitude.
    a0 = ack_cnt;
    enable = 1'b1; cfg_amp = 8'd100; start_req = 1'b1; ad_guard_active = 1'b1;
    repeat (10) @(negedge clk);
    ad_guard_active = 1'b0; cfg_amp = 8'd0;
    repeat (10) @(negedge clk);
    #1;
    start_req = 1'b0;
    check("block_no_ack", ack_cnt - a0, 0);
    check("block_idle", int'(state), 0);

    // Enable drop mid-ramp.
    request(8'd100, lat);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_state", int'(state), 0);
    check("abort_amp", int'(stim_amp), 0);
    enable = 1'b1;
    @(negedge clk);

    // Brake train long enough to saturate the brake counter.
    request(8'd100, lat);
    for (int i = 0; i < 260; i++) begin
      ad_guard_active = 1'b1;
      @(negedge clk);
      ad_guard_active = 1'b0;
      @(negedge clk);
    end
    wait_for(3'd0, 2100, "train_idle");
`ifdef BOREAL_VNS_BRAKE_CNT_EN
    check("bev_sat", int'(dut_bev), 255);
`endif

    // Async reset mid-burst.
    request(8'd100, lat);
    wait_for(3'd2, 100, "rst_reach_on");
    #2 rst = 1'b1;
    #1;
    check("async_rst_amp", int'(stim_amp), 0);
    check("async_rst_active", int'(stim_active), 0);
    check("async_rst_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    guard_left = 0;
    for (int k = 0; k < 12000; k++) begin
      @(negedge clk);
      enable = ($urandom % 64) != 0;
      start_req = ($urandom % 4) == 0;
      case ($urandom % 8)
        0: cfg_amp = 8'd0;
        1: cfg_amp = 8'(200 + $urandom % 56);
        default: cfg_amp = 8'($urandom % 256);
      endcase
      if (guard_left > 0) begin
        ad_guard_active = 1'b1;
        guard_left--;
      end else begin
        ad_guard_active = 1'b0;
        if ($urandom % 500 == 0) guard_left = 1 + $urandom % 6;
      end
    end
    @(negedge clk);
    ad_guard_active = 1'b0; start_req = 1'b0; enable = 1'b1;
    wait_for(3'd0, 2200, "final_idle");
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
